gui_frame_arbiter: RTL and testbench
====================================

Name: gui_frame_arbiter

Overview:
- Frame-synchronous arbiter for the GUI overlay configuration that feeds the delayed VGA timing datapath.
- Two game-logic requesters contend for one shared overlay register set: position, colour and owner.
- Updates commit only during vertical blanking, so the pixel stream never sees a mid-frame change.
- Sits between game logic and the overlay draw stage; also provides a frame counter and a commit strobe.

Parameters:
XW, 11, x-position width (matches hcount)
YW, 10, y-position width (matches vcount)
CW, 12, colour width (4:4:4 RGB)
FW, 16, frame counter width
X_RST, 0, reset value of xpos_out
Y_RST, 0, reset value of ypos_out
C_RST, 12'h000, reset value of rgb_out

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-low (0 = reset)
vblnk_in  in  1  vertical blank from the timing chain
req0  in  1  requester 0 update request
x0  in  XW  requester 0 x position
y0  in  YW  requester 0 y position
rgb0  in  CW  requester 0 colour
req1  in  1  requester 1 update request
x1  in  XW  requester 1 x position
y1  in  YW  requester 1 y position
rgb1  in  CW  requester 1 colour
ack0  out  1  one-cycle commit acknowledge to requester 0
ack1  out  1  one-cycle commit acknowledge to requester 1
xpos_out  out  XW  active overlay x
ypos_out  out  YW  active overlay y
rgb_out  out  CW  active overlay colour
owner_out  out  1  requester whose data is active
update_out  out  1  one-cycle pulse on every commit
frame_cnt  out  FW  count of vblank rising edges

Behaviour:
- Reset is asynchronous on rst low:
  - xpos_out=X_RST, ypos_out=Y_RST, rgb_out=C_RST, owner_out=0.
  - ack0=ack1=update_out=0, frame_cnt=0, state=IDLE.
  - last_owner=1, so requester 0 wins the first tie.
  - vblnk_q=1, so no spurious edge is seen if vblnk_in is high when reset releases.
- Reset asserted mid-operation aborts any grant. No ack is issued for the aborted cycle.
- Edge detect: vblnk_q <= vblnk_in every cycle. rise = vblnk_in & ~vblnk_q.
- frame_cnt increments on every rise, in any state. It wraps from all-ones to 0.
- Handshake:
  - A requester raises reqN and holds its data stable until ackN.
  - ackN is high for exactly one cycle.
  - The requester must drop reqN in the cycle after ackN. Otherwise it is treated as a new request for the next frame.
  - Dropping reqN before ack withdraws the request silently.
- FSM:
  - IDLE: wait. On rise -> ARB.
  - ARB (one cycle): sample req0/req1 in this cycle.
    - Neither requesting: -> HOLD, no commit.
    - One requesting: that requester wins.
    - Both requesting: winner = ~last_owner (round-robin).
    - With a winner -> COMMIT, winner registered.
  - COMMIT (one cycle): on entry to this cycle, xpos/ypos/rgb are loaded from the winner's inputs as sampled in ARB, owner_out=winner, last_owner=winner. The winner's ack and update_out are high for this cycle only. -> HOLD.
  - HOLD: wait while vblnk_in=1. On vblnk_in=0 -> IDLE.
- Latency: let edge E be the clock on which vblnk_in is first sampled high.
  - E+1: state=ARB.
  - E+2: outputs show new values; ack and update_out high.
  - E+3: ack and update_out low.
- At most one commit per frame.
- Requests that arrive after ARB wait for the next vblank.
- If vblnk_in falls during ARB or COMMIT, the commit still completes. The FSM then goes HOLD -> IDLE on the next cycle.
- A vblank shorter than 1 cycle is not supported.
- Outputs are held unchanged outside COMMIT.
- Data inputs never pass through combinationally to any output.

Test Plan:
- Reset with vblnk_in=1, then release → no ack and no update; frame_cnt=0 until the first 0→1 vblank edge.
- req0 only, x0=400, y0=300, rgb0=12'hF00; vblank rise at edge E → at E+2: xpos=400, ypos=300, rgb=F00, owner=0, ack0=1, update=1, ack1=0; at E+3: pulses low.
- Both requesting for 3 consecutive frames → grants 0, 1, 0; the loser keeps req high and wins the next frame; exactly one ack per frame.
- req1 raised one cycle after ARB → no commit this frame; commit at the following vblank with owner_out=1.
- Assert rst low during COMMIT → all outputs at reset values immediately (async); no ack pulse; frame_cnt=0.
- Run 65536 vblank rises with no requests → frame_cnt wraps to 0; xpos/ypos/rgb unchanged; update_out never pulses.

Source files
------------

// File: rtl/gui_frame_arbiter.sv
// Frame-synchronous arbiter for the GUI overlay register set: two requesters,
// round-robin on ties, commits only at the start of vertical blanking.
module gui_frame_arbiter #(
    parameter int XW = 11,
    parameter int YW = 10,
    parameter int CW = 12,
    parameter int FW = 16,
    parameter logic [XW-1:0] X_RST = '0,
    parameter logic [YW-1:0] Y_RST = '0,
    parameter logic [CW-1:0] C_RST = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vblnk_in,
    input  logic          req0,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [CW-1:0] rgb0,
    input  logic          req1,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] rgb1,
    output logic          ack0,
    output logic          ack1,
    output logic [XW-1:0] xpos_out,
    output logic [YW-1:0] ypos_out,
    output logic [CW-1:0] rgb_out,
    output logic          owner_out,
    output logic          update_out,
    output logic [FW-1:0] frame_cnt,
    output logic [1:0]    dbg_state
);

    // Handshake: reqN high with data held stable until ackN (one cycle);
    // reqN still high the cycle after ackN counts as a new request.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_vblnk_q;
    logic          r_last_owner;
    logic          w_rise;
    logic          w_grant;
    logic          w_winner;
    logic [XW-1:0] r_xpos;
    logic [YW-1:0] r_ypos;
    logic [CW-1:0] r_rgb;
    logic          r_owner;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_update;
    logic [FW-1:0] r_frame_cnt;

    assign w_rise = vblnk_in & ~r_vblnk_q;

    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_winner = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_next = ST_ARB;
            end
            ST_ARB: begin
                w_grant  = req0 | req1;
                // Tie goes to whoever did not win last time.
                w_winner = (req0 & req1) ? ~r_last_owner : req1;
                w_next   = w_grant ? ST_COMMIT : ST_HOLD;
            end
            ST_COMMIT: begin
                w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!vblnk_in) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_vblnk_q    <= 1'b1;
            r_last_owner <= 1'b1;
            r_xpos       <= X_RST;
            r_ypos       <= Y_RST;
            r_rgb        <= C_RST;
            r_owner      <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_update     <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state   <= w_next;
            r_vblnk_q <= vblnk_in;
            r_ack0    <= w_grant & ~w_winner;
            r_ack1    <= w_grant & w_winner;
            r_update  <= w_grant;
            if (w_rise) r_frame_cnt <= r_frame_cnt + 1'b1;
            // Load at the ARB->COMMIT edge so the new set is visible in COMMIT.
            if (w_grant) begin
                r_xpos       <= w_winner ? x1 : x0;
                r_ypos       <= w_winner ? y1 : y0;
                r_rgb        <= w_winner ? rgb1 : rgb0;
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
            end
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign xpos_out   = r_xpos;
    assign ypos_out   = r_ypos;
    assign rgb_out    = r_rgb;
    assign owner_out  = r_owner;
    assign update_out = r_update;
    assign frame_cnt  = r_frame_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gui_frame_arbiter.sv
// Bench for gui_frame_arbiter: directed frames, commits checked by a monitor
// against an expected queue, plus timing/reset/wrap spot checks.
module tb_gui_frame_arbiter;

    localparam int XW  = 11;
    localparam int YW  = 10;
    localparam int CW  = 12;
    localparam int FW  = 8;
    localparam int SBW = 1 + XW + YW + CW;

    logic          clk;
    logic          rst;
    logic          vblnk_in;
    logic          req0;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [CW-1:0] rgb0;
    logic          req1;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] rgb1;
    logic          ack0;
    logic          ack1;
    logic [XW-1:0] xpos_out;
    logic [YW-1:0] ypos_out;
    logic [CW-1:0] rgb_out;
    logic          owner_out;
    logic          update_out;
    logic [FW-1:0] frame_cnt;
    logic [1:0]    dbg_state;

    gui_frame_arbiter #(.XW(XW), .YW(YW), .CW(CW), .FW(FW)) dut (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in),
        .req0(req0), .x0(x0), .y0(y0), .rgb0(rgb0),
        .req1(req1), .x1(x1), .y1(y1), .rgb1(rgb1),
        .ack0(ack0), .ack1(ack1),
        .xpos_out(xpos_out), .ypos_out(ypos_out), .rgb_out(rgb_out),
        .owner_out(owner_out), .update_out(update_out),
        .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int             n_tests = 0;
    int             n_fail  = 0;
    int             n_upd   = 0;
    int             n_ack0  = 0;
    int             n_ack1  = 0;
    int             exp_frame;
    logic           exp_last;
    logic [SBW-1:0] exp_q[$];
    logic [SBW-1:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vbl_rise();
        vblnk_in  = 1'b1;
        exp_frame = (exp_frame + 1) % (1 << FW);
    endtask

    task automatic push(input logic o, input logic [XW-1:0] x, input logic [YW-1:0] y,
                        input logic [CW-1:0] c);
        exp_q.push_back({o, x, y, c});
        exp_last = o;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_xpos"},   xpos_out,   0);
        check({tag, "_ypos"},   ypos_out,   0);
        check({tag, "_rgb"},    rgb_out,    0);
        check({tag, "_owner"},  owner_out,  0);
        check({tag, "_ack0"},   ack0,       0);
        check({tag, "_ack1"},   ack1,       0);
        check({tag, "_update"}, update_out, 0);
        check({tag, "_frame"},  frame_cnt,  0);
        check({tag, "_state"},  dbg_state,  0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (update_out) begin
                n_upd++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: owner=%0d x=%0d y=%0d rgb=0x%0h, expected no commit",
                             owner_out, xpos_out, ypos_out, rgb_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("commit_owner", owner_out, mon_e[SBW-1]);
                    check("commit_x",     xpos_out,  mon_e[CW+YW +: XW]);
                    check("commit_y",     ypos_out,  mon_e[CW +: YW]);
                    check("commit_rgb",   rgb_out,   mon_e[CW-1:0]);
                    check("commit_ack",   {ack1, ack0}, mon_e[SBW-1] ? 2'b10 : 2'b01);
                end
            end else if (ack0 || ack1) begin
                n_tests++;
                n_fail++;
                $display("FAIL ack_without_update: ack0=%0d ack1=%0d, expected both 0", ack0, ack1);
            end
            if (ack0) n_ack0++;
            if (ack1) n_ack1++;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int upd_before;
        int a0;
        int a1;
        logic w;

        rst = 1'b0; vblnk_in = 1'b1;
        req0 = 1'b0; x0 = '0; y0 = '0; rgb0 = '0;
        req1 = 1'b0; x1 = '0; y1 = '0; rgb1 = '0;
        exp_frame = 0; exp_last = 1'b1;

        // Reset held with vblank high, then released: no edge, no commit.
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(4);
        check("no_edge_frame", frame_cnt, 0);
        check("no_edge_updates", n_upd, 0);
        vblnk_in = 1'b0;
        tick(3);
        check("no_edge_frame_low", frame_cnt, 0);

        // Contention over three frames: grants alternate 0, 1, 0.
        x0 = 11'd100; y0 = 10'd50; rgb0 = 12'h00F;
        x1 = 11'd200; y1 = 10'd60; rgb1 = 12'h0F0;
        req0 = 1'b1; req1 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            a0 = n_ack0;
            a1 = n_ack1;
            w  = ~exp_last;
            push(w, w ? x1 : x0, w ? y1 : y0, w ? rgb1 : rgb0);
            vbl_rise();
            tick(2);
            check("contend_grant_seq", owner_out, (f == 1) ? 1 : 0);
            if (w) req1 = 1'b0; else req0 = 1'b0;
            tick(1);
            if (w) begin x1 = x1 + 11'd1; req1 = 1'b1; end
            else   begin x0 = x0 + 11'd1; req0 = 1'b1; end
            tick(2);
            vblnk_in = 1'b0;
            tick(3);
            check("contend_one_ack", (n_ack0 - a0) + (n_ack1 - a1), 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(2);

        // Request raised after ARB waits for the next frame.
        upd_before = n_upd;
        vbl_rise();
        tick(1);
        check("late_state_arb", dbg_state, 1);
        tick(1);
        check("late_state_hold", dbg_state, 3);
        x1 = 11'd700; y1 = 10'd400; rgb1 = 12'hABC; req1 = 1'b1;
        tick(2);
        vblnk_in = 1'b0;
        tick(3);
        check("late_no_commit", n_upd, upd_before);
        push(1'b1, 11'd700, 10'd400, 12'hABC);
        vbl_rise();
        tick(2);
        check("late_owner1", owner_out, 1);
        check("late_ack1", ack1, 1);
        req1 = 1'b0;
        tick(2);
        vblnk_in = 1'b0;
        tick(3);

        // Single requester, cycle-exact latency.
        x0 = 11'd400; y0 = 10'd300; rgb0 = 12'hF00; req0 = 1'b1;
        push(1'b0, 11'd400, 10'd300, 12'hF00);
        vbl_rise();
        tick(1);
        check("e1_state_arb", dbg_state, 1);
        check("e1_frame", frame_cnt, exp_frame);
        check("e1_no_update", update_out, 0);
        tick(1);
        check("e2_xpos", xpos_out, 400);
        check("e2_ypos", ypos_out, 300);
        check("e2_rgb", rgb_out, 12'hF00);
        check("e2_owner", owner_out, 0);
        check("e2_ack0", ack0, 1);
        check("e2_ack1", ack1, 0);
        check("e2_update", update_out, 1);
        check("e2_state_commit", dbg_state, 2);
        req0 = 1'b0;
        tick(1);
        check("e3_ack0", ack0, 0);
        check("e3_update", update_out, 0);
        check("e3_xpos_held", xpos_out, 400);
        check("e3_state_hold", dbg_state, 3);
        tick(1);
        vblnk_in = 1'b0;
        tick(2);
        check("idle_after_hold", dbg_state, 0);

        // Frame counter wrap with one-cycle vblanks and no requests.
        for (int i = 0; i < (1 << FW); i++) begin
            vbl_rise();
            tick(1);
            vblnk_in = 1'b0;
            tick(2);
            if (exp_frame == 0) check("frame_wrap_zero", frame_cnt, 0);
        end
        check("wrap_frame", frame_cnt, exp_frame);
        check("wrap_xpos_held", xpos_out, 400);
        check("wrap_ypos_held", ypos_out, 300);
        check("wrap_rgb_held", rgb_out, 12'hF00);
        check("wrap_owner_held", owner_out, 0);

        // Reset asserted during COMMIT aborts the grant.
        x1 = 11'd55; y1 = 10'd66; rgb1 = 12'h123; req1 = 1'b1;
        upd_before = n_upd;
        vbl_rise();
        tick(1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);
        exp_frame = 0; exp_last = 1'b1;
        check_reset_outputs("abort");
        req1 = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(3);
        check("abort_frame_after_release", frame_cnt, 0);
        check("abort_state_idle", dbg_state, 0);
        check("abort_no_commit", n_upd, upd_before);
        vblnk_in = 1'b0;
        tick(2);

        // First tie after reset goes to requester 0.
        x0 = 11'd9; y0 = 10'd8; rgb0 = 12'h777; x1 = 11'd1; y1 = 10'd2; rgb1 = 12'h333;
        req0 = 1'b1; req1 = 1'b1;
        push(1'b0, 11'd9, 10'd8, 12'h777);
        vbl_rise();
        tick(2);
        check("post_reset_tie_owner", owner_out, 0);
        req0 = 1'b0; req1 = 1'b0;
        tick(2);
        vblnk_in = 1'b0;
        tick(3);
        check("post_reset_frame", frame_cnt, exp_frame);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
